// File: rtl/branch_resolve_unit.sv
// Resolves B/Bcc against bypassed SZCV flags, registers the branch target and runs a counted flush.
// Branch outputs are one cycle after acceptance, wb_dest is DEST_STAGES cycles after; stall freezes everything.
module branch_resolve_unit #(
    parameter int ADDR_W       = 16,
    parameter int DISP_W       = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int DEST_STAGES  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [15:0]       instr,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flag_we,
    input  logic [3:0]        flag_in,
    output logic [3:0]        flags_q,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_target,
    output logic              flush,
    output logic [2:0]        wb_dest,
    output logic              wb_valid
);

    localparam logic [4:0] OP_B   = 5'b10100;
    localparam logic [4:0] OP_BCC = 5'b10111;

    logic [3:0]        r_flags;
    logic              r_br_taken;
    logic [ADDR_W-1:0] r_br_target;
    logic [2:0]        r_flush_cnt;
    logic              r_pipe_vld  [DEST_STAGES];
    logic [2:0]        r_pipe_dest [DEST_STAGES];

    logic [3:0]        w_eff_flags;
    logic              w_flush;
    logic              w_accept;
    logic              w_cond;
    logic              w_taken;
    logic              w_sv;
    logic [ADDR_W-1:0] w_disp;
    logic [ADDR_W-1:0] w_target;
    logic [2:0]        w_dest;
    logic              w_dest_vld;

    // An ALU flag write in the same cycle is visible to the branch being evaluated.
    assign w_eff_flags = flag_we ? flag_in : r_flags;
    assign w_sv        = w_eff_flags[3] ^ w_eff_flags[0];
    assign w_flush     = (r_flush_cnt != 3'd0);
    assign w_accept    = in_valid & ~w_flush;

    always_comb begin
        w_cond = 1'b0;
        if (instr[15:11] == OP_B) begin
            w_cond = 1'b1;
        end else if (instr[15:11] == OP_BCC) begin
            case (instr[10:8])
                3'b000:  w_cond = w_eff_flags[2];
                3'b001:  w_cond = w_sv;
                3'b010:  w_cond = w_eff_flags[2] | w_sv;
                3'b011:  w_cond = ~w_eff_flags[2];
                3'b100:  w_cond = w_eff_flags[1];
                3'b101:  w_cond = ~w_eff_flags[1];
                3'b110:  w_cond = ~w_sv;
                default: w_cond = 1'b0;
            endcase
        end
    end

    assign w_taken  = w_accept & w_cond;
    assign w_disp   = {{(ADDR_W-DISP_W){instr[DISP_W-1]}}, instr[DISP_W-1:0]};
    assign w_target = pc + ADDR_W'(1) + w_disp;

    // Loads carry their destination in the opcode field; everything else in [10:8].
    assign w_dest     = (instr[15:14] == 2'b00) ? instr[13:11] : instr[10:8];
    assign w_dest_vld = w_accept & (instr[15:14] != 2'b10);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags     <= '0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_flush_cnt <= '0;
            for (int i = 0; i < DEST_STAGES; i++) begin
                r_pipe_vld[i]  <= 1'b0;
                r_pipe_dest[i] <= '0;
            end
        end else if (!stall) begin
            if (flag_we) begin
                r_flags <= flag_in;
            end
            r_br_taken <= w_taken;
            if (w_taken) begin
                r_br_target <= w_target;
                r_flush_cnt <= 3'(FLUSH_CYCLES);
            end else if (w_flush) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
            r_pipe_vld[0]  <= w_dest_vld;
            r_pipe_dest[0] <= w_dest;
            for (int i = 1; i < DEST_STAGES; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_dest[i] <= r_pipe_dest[i-1];
            end
        end
    end

    assign flags_q   = r_flags;
    assign br_taken  = r_br_taken;
    assign br_target = r_br_target;
    assign flush     = w_flush;
    assign wb_valid  = r_pipe_vld[DEST_STAGES-1];
    assign wb_dest   = r_pipe_dest[DEST_STAGES-1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and random stimulus for branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

    localparam int AW = 16;
    localparam int DS = 3;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          in_valid = 1'b0;
    logic [15:0]   instr = '0;
    logic [AW-1:0] pc = '0;
    logic          flag_we = 1'b0;
    logic [3:0]    flag_in = '0;
    logic [3:0]    flags_q;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          flush;
    logic [2:0]    wb_dest;
    logic          wb_valid;

    int tests = 0;
    int fails = 0;

    logic [3:0]  m_flags;
    bit          m_taken;
    logic [15:0] m_target;
    int          m_flush;
    logic [3:0]  m_q[$];

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .ADDR_W(AW), .DISP_W(8), .FLUSH_CYCLES(FC), .DEST_STAGES(DS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(in_valid),
        .instr(instr), .pc(pc), .flag_we(flag_we), .flag_in(flag_in),
        .flags_q(flags_q), .br_taken(br_taken), .br_target(br_target),
        .flush(flush), .wb_dest(wb_dest), .wb_valid(wb_valid)
    );

    function automatic bit is_taken(logic [15:0] ins, logic [3:0] f);
        bit s, z, c, v;
        s = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (ins[15:11] == 5'b10100) return 1'b1;
        if (ins[15:11] != 5'b10111) return 1'b0;
        case (int'(ins[10:8]))
            0: return z;
            1: return s != v;
            2: return z || (s != v);
            3: return !z;
            4: return c;
            5: return !c;
            6: return s == v;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model using the inputs as seen at the coming edge, then compare.
    task automatic cycle();
        logic [3:0] eff;
        bit acc, tk;
        int d;
        logic [2:0] dst;
        if (!rst_n) begin
            m_flags = '0; m_taken = 1'b0; m_target = '0; m_flush = 0;
            m_q = {};
            for (int i = 0; i < DS; i++) m_q.push_back(4'h0);
        end else if (!stall) begin
            eff = flag_we ? flag_in : m_flags;
            acc = in_valid && (m_flush == 0);
            tk  = acc && is_taken(instr, eff);
            m_taken = tk;
            if (tk) begin
                d = int'(instr[7:0]);
                if (d > 127) d -= 256;
                m_target = 16'((int'(pc) + 1 + d + 65536) % 65536);
            end
            m_flush = tk ? FC : ((m_flush > 0) ? m_flush - 1 : 0);
            if (flag_we) m_flags = flag_in;
            dst = (instr[15:14] == 2'b00) ? instr[13:11] : instr[10:8];
            m_q.push_back({(acc && instr[15:14] != 2'b10) ? 1'b1 : 1'b0, dst});
            void'(m_q.pop_front());
        end
        @(posedge clk);
        #1;
        chk("flags_q", 32'(flags_q), 32'(m_flags));
        chk("br_taken", 32'(br_taken), 32'(m_taken));
        chk("br_target", 32'(br_target), 32'(m_target));
        chk("flush", 32'(flush), 32'(m_flush != 0));
        chk("wb_valid", 32'(wb_valid), 32'(m_q[0][3]));
        if (m_q[0][3]) chk("wb_dest", 32'(wb_dest), 32'(m_q[0][2:0]));
    endtask

    task automatic idle(int n);
        in_valid = 1'b0; flag_we = 1'b0; instr = '0;
        repeat (n) cycle();
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        cycle(); cycle();
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Unconditional branch, then a writer squashed by the flush
        instr = 16'hA0FE; pc = 16'h0010; in_valid = 1'b1;
        cycle();
        chk("b_taken", 32'(br_taken), 32'd1);
        chk("b_target", 32'(br_target), 32'h000F);
        chk("b_flush1", 32'(flush), 32'd1);
        instr = 16'h4000;
        cycle();
        chk("b_pulse_once", 32'(br_taken), 32'd0);
        chk("b_flush2", 32'(flush), 32'd1);
        idle(1);
        chk("b_flush_end", 32'(flush), 32'd0);
        idle(DS);
        chk("squashed_no_wb", 32'(wb_valid), 32'd0);

        // Same-cycle flag bypass
        flag_we = 1'b1; flag_in = 4'b0100; instr = 16'hB800; pc = 16'h0020; in_valid = 1'b1;
        cycle();
        chk("bypass_be", 32'(br_taken), 32'd1);
        chk("bypass_tgt", 32'(br_target), 32'h0021);
        flag_we = 1'b0; instr = 16'hBB00;
        cycle();
        chk("bne_not_taken", 32'(br_taken), 32'd0);
        chk("bypass_flags", 32'(flags_q), 32'h4);
        idle(2);

        // Target wrap, then reset in the middle of the flush
        instr = 16'hA005; pc = 16'hFFFF; in_valid = 1'b1;
        cycle();
        chk("wrap_target", 32'(br_target), 32'h0005);
        idle(1);
        chk("mid_flush", 32'(flush), 32'd1);
        rst_n = 1'b0;
        cycle();
        chk("rst_mid_flush", 32'(flush), 32'd0);
        chk("rst_flags", 32'(flags_q), 32'd0);
        chk("rst_br_taken", 32'(br_taken), 32'd0);
        chk("rst_target", 32'(br_target), 32'd0);
        rst_n = 1'b1;
        idle(DS);

        // Destination pipe, unstalled
        in_valid = 1'b1; instr = 16'h1A00; cycle();
        instr = 16'h8500; cycle();
        idle(1);
        chk("dp_valid", 32'(wb_valid), 32'd1);
        chk("dp_dest3", 32'(wb_dest), 32'd3);
        idle(1);
        chk("dp_dest5", 32'(wb_dest), 32'd5);
        chk("dp_branch_nowb", 32'(wb_valid), 32'd0);
        idle(DS);

        // Destination pipe with two stalled cycles in between
        in_valid = 1'b1; instr = 16'h1A00; cycle();
        instr = 16'h8500; cycle();
        in_valid = 1'b0; instr = 16'h0000;
        stall = 1'b1; cycle(); cycle();
        chk("dp_stall_hold", 32'(wb_valid), 32'd0);
        stall = 1'b0; cycle();
        chk("dp_stall_valid", 32'(wb_valid), 32'd1);
        chk("dp_stall_dest3", 32'(wb_dest), 32'd3);
        cycle();
        chk("dp_stall_dest5", 32'(wb_dest), 32'd5);
        idle(DS);

        // Condition sweep over all flag values
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 16; f++) begin
                flag_we = 1'b1; flag_in = 4'(f); in_valid = 1'b1;
                pc = 16'($urandom);
                instr = {5'b10111, 3'(c), 8'($urandom)};
                cycle();
                if (c == 7) chk("cond111_never", 32'(br_taken), 32'd0);
                idle(2);
            end
        end
        for (int f = 0; f < 16; f++) begin
            flag_we = 1'b1; flag_in = 4'(f); in_valid = 1'b1;
            instr = {5'b10110, 3'($urandom), 8'($urandom)};
            cycle();
            chk("op10110_never", 32'(br_taken), 32'd0);
        end
        idle(2);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst_n    = ($urandom_range(99) != 0);
            stall    = ($urandom_range(7) == 0);
            in_valid = $urandom_range(1);
            flag_we  = $urandom_range(1);
            flag_in  = 4'($urandom);
            pc       = 16'($urandom);
            instr    = 16'($urandom);
            case ($urandom_range(3))
                0: instr[15:11] = 5'b10100;
                1: instr[15:11] = 5'b10111;
                default: ;
            endcase
            cycle();
        end
        rst_n = 1'b1; stall = 1'b0;
        idle(DS);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Next-generation branch/writeback-destination resolver for the 16-bit CPU pipeline.
- Holds the SZCV flag register with same-cycle bypass and decodes B and conditional-branch instructions, including an extended condition set.
- Computes a registered branch target and drives a counted pipeline flush.
- Carries each instruction's register-file destination through a parametrised delay line to the writeback stage.

Parameters:
- ADDR_W, 16, PC / branch-target width in bits.
- DISP_W, 8, displacement field width, instr[DISP_W-1:0], sign-extended to ADDR_W.
- FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch (1..7).
- DEST_STAGES, 3, cycles between instruction acceptance and wb_dest output (1..8).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- stall  input  1  pipeline stall; holds all state
- in_valid  input  1  instr/pc valid this cycle
- instr  input  16  instruction in execute stage
- pc  input  ADDR_W  address of instr
- flag_we  input  1  ALU flag write strobe
- flag_in  input  4  new flags {S,Z,C,V} = [3:0]
- flags_q  output  4  current flag register
- br_taken  output  1  registered one-cycle taken pulse
- br_target  output  ADDR_W  target, valid while br_taken=1
- flush  output  1  squash younger stages
- wb_dest  output  3  destination register at writeback
- wb_valid  output  1  wb_dest valid

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0. Flags_q, flush counter, dest pipeline and valid bits all 0. Reset wins over every other input, including mid-flush.
- Stall=1: every register holds, including flags, flush counter and dest pipe; flag_we and in_valid are ignored. br_taken is held too: a pulse is not repeated; it is held as-is for the stalled cycles.
- Flags: if flag_we and !stall, flags_q <= flag_in. Effective flags for evaluation = flag_we ? flag_in : flags_q (bypass).
- Accept = in_valid & !stall & !flush. Squashed instructions (flush=1) neither branch nor enter the dest pipe.
- Decode on opcode instr[15:11]:
  - 10100 = B, always taken.
  - 10111 = conditional branch, cond in instr[10:8] (S=f[3], Z=f[2], C=f[1], V=f[0]):
    - 000 BE: Z
    - 001 BLT: S^V
    - 010 BLE: Z|(S^V)
    - 011 BNE: !Z
    - 100 BC: C
    - 101 BNC: !C
    - 110 BGE: !(S^V)
    - 111: never taken
  - Any other opcode: not a branch.
- Taken (accepted & condition true), at the next posedge:
  - br_taken=1 for exactly one cycle.
  - br_target = pc + 1 + sext(instr[DISP_W-1:0]), modulo 2^ADDR_W (wraps silently).
  - flush counter loads FLUSH_CYCLES.
- flush = (counter != 0). The counter decrements each non-stalled cycle. A taken branch cannot occur while flush=1.
- Not-taken or non-branch: br_taken=0; br_target holds its previous value.
- Dest select: instr[15:14]==00 (load) -> instr[13:11]; otherwise -> instr[10:8].
- Dest pipe: DEST_STAGES-deep shift of {valid, dest}, advancing on !stall. Entry valid = accept & (instr[15:14] != 2'b10). Branches and stores write nothing; store = 01 is treated as a writer only if the ISA table marks it, and for this block 01 is a writer.
- wb_valid/wb_dest appear DEST_STAGES non-stalled cycles after acceptance.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: rst_n=0 mid-flush (counter=1) -> next cycle flush=0, flags_q=0, wb_valid=0, br_taken=0.
- Unconditional: B with pc=0x0010, disp=0xFE -> next cycle br_taken=1, br_target=0x000F; flush high for exactly 2 cycles; 0x4000 presented during flush -> no wb_valid afterward.
- Bypass: flags_q=0000; same cycle flag_we=1, flag_in=0100 (Z) and BE (0xB8xx) -> taken. BNE in the following cycle -> not taken; flags_q=0100.
- Conditions: sweep cond 000..111 over S^V and C combinations -> taken matches table; 111 never taken; opcode 10110 never taken.
- Dest pipe (DEST_STAGES=3): instr 0x1A00 (load, dest=3) at cycle t -> wb_valid=1, wb_dest=3 at t+3. 0x8500 (dest=5) at t+1 -> wb_dest=5 at t+4. Stall 2 cycles in between -> both delayed by exactly 2.
- Wrap: ADDR_W=16, pc=0xFFFF, disp=0x05 -> br_target=0x0005.
